// File: rtl/basic_fsm_pkg.sv
// State codes and state width for the basic_fsm sequencer.
package basic_fsm_pkg;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE  = 3'b000;
  localparam logic [STATE_W-1:0] S1    = 3'b001;
  localparam logic [STATE_W-1:0] S2    = 3'b010;
  localparam logic [STATE_W-1:0] S3    = 3'b011;
  localparam logic [STATE_W-1:0] FINAL = 3'b100;
endpackage

// File: rtl/basic_fsm_timer.sv
// Dwell counter for basic_fsm: expired flags TIMEOUT_CYCLES-1 unchanged cycles.
// Latency: expired is a registered-count compare; clr takes effect on the next edge.
module basic_fsm_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic expired
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_LAST);
endmodule

// File: rtl/basic_fsm.sv
// Five-state Moore sequencer on qualifiers a/b; one edge input-to-state latency, no backpressure.
// Optional dwell timeout forcing IDLE is enabled by defining BASIC_FSM_TIMEOUT_EN.
module basic_fsm
  import basic_fsm_pkg::*;
`ifdef BASIC_FSM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic         clock,
  input  logic         reset,
  input  logic         a,
  input  logic         b,
  output logic         output_1,
  output logic         output_2,
  output logic         output_3,
  output logic         output_4,
  output logic [2:0]   status
);
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] table_nxt;

  always_comb begin
    table_nxt = IDLE;
    case (state_q)
      IDLE:    table_nxt = a ? S1 : IDLE;
      S1:      table_nxt = b ? S2 : (a ? S1 : IDLE);
      S2:      table_nxt = !a ? S1 : (b ? S3 : S2);
      S3:      table_nxt = b ? S3 : FINAL;
      FINAL:   table_nxt = a ? S1 : IDLE;
      default: table_nxt = IDLE;
    endcase
  end

`ifdef BASIC_FSM_TIMEOUT_EN
  logic timer_clr;
  logic timer_expired;

  // A real transition on the expiry edge wins over the forced return to IDLE.
  always_comb begin
    state_d = table_nxt;
    if (timer_expired && (table_nxt == state_q) && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  assign timer_clr = (state_q == IDLE) || (state_d != state_q);

  basic_fsm_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr     (timer_clr),
    .expired (timer_expired)
  );
`else
  always_comb begin
    state_d = table_nxt;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign output_1 = (state_q == S1);
  assign output_2 = (state_q == S2);
  assign output_3 = (state_q == S3);
  assign output_4 = (state_q == FINAL);
  assign status   = state_q;
endmodule

// File: tb/tb_basic_fsm.sv
// Bench for basic_fsm: directed vector table, hand-written corner sequences, random vs reference model.
module tb_basic_fsm;
`ifdef BASIC_FSM_TIMEOUT_EN
  localparam int TMO = 4;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       output_1, output_2, output_3, output_4;
  logic [2:0] status;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

`ifdef BASIC_FSM_TIMEOUT_EN
  basic_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
`else
  basic_fsm dut (
`endif
    .clock    (clock),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .output_1 (output_1),
    .output_2 (output_2),
    .output_3 (output_3),
    .output_4 (output_4),
    .status   (status)
  );

  // Reference model: phases numbered 0=idle,1..3=steps,4=final; the number is the monitored code.
  int m_phase = 0;
  int m_held  = 0;

  function automatic int rule(input int p, input bit ia, input bit ib);
    if (p == 0) return ia ? 1 : 0;
    if (p == 1) return ib ? 2 : (ia ? 1 : 0);
    if (p == 2) return (ia && ib) ? 3 : (!ia ? 1 : 2);
    if (p == 3) return ib ? 3 : 4;
    if (p == 4) return ia ? 1 : 0;
    return 0;
  endfunction

  task automatic model_step(input bit ir, input bit ia, input bit ib);
    int n;
    if (ir) begin
      m_phase = 0;
      m_held  = 0;
      return;
    end
    n = rule(m_phase, ia, ib);
    if (n != m_phase || m_phase == 0) begin
      m_phase = n;
      m_held  = 0;
    end else begin
      m_held++;
`ifdef BASIC_FSM_TIMEOUT_EN
      if (m_held == TMO) begin
        m_phase = 0;
        m_held  = 0;
      end
`endif
    end
  endtask

  function automatic logic [6:0] expect_vec(input int p);
    logic [6:0] v;
    v[2:0] = p[2:0];
    v[3] = (p == 1);
    v[4] = (p == 2);
    v[5] = (p == 3);
    v[6] = (p == 4);
    return v;
  endfunction

  task automatic step(input bit ir, input bit ia, input bit ib, input int exp_p, input string name);
    logic [6:0] got;
    @(negedge clock);
    reset = ir;
    a = ia;
    b = ib;
    @(posedge clock);
    #1;
    model_step(ir, ia, ib);
    got = {output_4, output_3, output_2, output_1, status};
    n_cmp++;
    if (got !== expect_vec(exp_p)) begin
      n_bad++;
      $display("FAIL %s: got {o4..o1,status}=%b required %b", name, got, expect_vec(exp_p));
    end
  endtask

  typedef struct {
    bit r;
    bit a;
    bit b;
    int exp_p;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1, 1, 1, 0};
    vecs[1]  = '{0, 1, 1, 1};
    vecs[2]  = '{0, 0, 1, 2};
    vecs[3]  = '{0, 1, 1, 3};
    vecs[4]  = '{0, 0, 0, 4};
    vecs[5]  = '{0, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 0};
    vecs[7]  = '{0, 1, 0, 1};
    vecs[8]  = '{0, 1, 0, 1};
    vecs[9]  = '{0, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 1};
    vecs[11] = '{0, 0, 1, 2};
    vecs[12] = '{0, 1, 0, 2};
    vecs[13] = '{0, 0, 1, 1};
    vecs[14] = '{0, 1, 1, 2};
    vecs[15] = '{0, 1, 1, 3};
    vecs[16] = '{0, 0, 0, 4};
    vecs[17] = '{0, 1, 0, 1};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].exp_p, $sformatf("vec%0d", i));
    end

    // S1 -> S2 -> S3, then hold S3 with b=1
    step(0, 0, 1, 2, "to_s2");
    step(0, 1, 1, 3, "to_s3");
    for (int i = 0; i < 10; i++) begin
`ifdef BASIC_FSM_TIMEOUT_EN
      step(0, 0, 1, (i < TMO - 1) ? 3 : 0, $sformatf("s3_hold_tmo%0d", i));
`else
      step(0, 0, 1, 3, $sformatf("s3_hold%0d", i));
`endif
    end

    // Mid-run reset from S3
    step(1, 0, 0, 0, "reset_pre");
    step(0, 1, 0, 1, "mr_s1");
    step(0, 1, 1, 2, "mr_s2");
    step(0, 1, 1, 3, "mr_s3");
    step(1, 1, 1, 0, "midrun_reset");
    step(0, 1, 1, 1, "after_reset_s1");

    // Random a/b against the model; occasional reset
    for (int i = 0; i < 1000; i++) begin
      bit rr, ra, rb;
      int p_exp;
      rr = ($urandom_range(0, 49) == 0);
      ra = 1'($urandom);
      rb = 1'($urandom);
      if (rr) begin
        p_exp = 0;
      end else begin
        p_exp = rule(m_phase, ra, rb);
`ifdef BASIC_FSM_TIMEOUT_EN
        if (p_exp == m_phase && m_phase != 0 && m_held + 1 == TMO) p_exp = 0;
`endif
      end
      step(rr, ra, rb, p_exp, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
